// File: rtl/store_data_align.sv
// Store data alignment: turns a core store request (funct3, byte address,
// LSB-justified rs2 data) into one or two lane-aligned word writes.
// Stores that straddle a word boundary are issued as two back-to-back
// beats with no bubble between them.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; mem_valid low
// BEAT0 | first (or only) word write presented, waiting for mem_ready
// BEAT1 | second word of a split store presented, waiting for mem_ready

module store_data_align #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic [3:0]        mem_be,
   output logic              busy,
   output logic              err_illegal
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d;
   logic [WIDTH-1:0]    wdata1_q, wdata1_d;
   logic [3:0]          be1_q, be1_d;

   logic                legal;
   logic [3:0]          mask;
   logic [WIDTH-1:0]    data_masked;
   logic [1:0]          off;
   logic [ADDR_W-1:0]   base;
   logic [7:0]          be_wide;
   logic [2*WIDTH-1:0]  data_wide;

   // Request decode: size mask, zero-extended data and the shifted
   // 8-lane enable / 64-bit data window spanning two words.
   always_comb begin
      legal       = 1'b1;
      mask        = 4'b0000;
      data_masked = '0;
      unique case (req_funct3)
         3'b000: begin
            mask        = 4'b0001;
            data_masked = {{(WIDTH-8){1'b0}}, req_data[7:0]};
         end
         3'b001: begin
            mask        = 4'b0011;
            data_masked = {{(WIDTH-16){1'b0}}, req_data[15:0]};
         end
         3'b010: begin
            mask        = 4'b1111;
            data_masked = req_data;
         end
         default: legal = 1'b0;
      endcase
      off       = req_addr[1:0];
      base      = {req_addr[ADDR_W-1:2], 2'b00};
      be_wide   = {4'b0000, mask} << off;
      data_wide = {{WIDTH{1'b0}}, data_masked} << {off, 3'b000};
   end

   // Next-state and registered output logic.
   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      err_d       = 1'b0;
      addr1_d     = addr1_q;
      wdata1_d    = wdata1_q;
      be1_d       = be1_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (legal) begin
                  state_d     = BEAT0;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = base;
                  mem_wdata_d = data_wide[WIDTH-1:0];
                  mem_be_d    = be_wide[3:0];
                  addr1_d     = base + ADDR_W'(4);
                  wdata1_d    = data_wide[2*WIDTH-1:WIDTH];
                  be1_d       = be_wide[7:4];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         BEAT0: begin
            if (mem_ready) begin
               if (be1_q != 4'b0000) begin
                  state_d     = BEAT1;
                  mem_addr_d  = addr1_q;
                  mem_wdata_d = wdata1_q;
                  mem_be_d    = be1_q;
               end else begin
                  state_d     = IDLE;
                  mem_valid_d = 1'b0;
               end
            end
         end
         BEAT1: begin
            if (mem_ready) begin
               state_d     = IDLE;
               mem_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any pending beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'b0000;
         err_q       <= 1'b0;
         addr1_q     <= '0;
         wdata1_q    <= '0;
         be1_q       <= 4'b0000;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         err_q       <= err_d;
         addr1_q     <= addr1_d;
         wdata1_q    <= wdata1_d;
         be1_q       <= be1_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign err_illegal = err_q;

endmodule

// File: tb/tb_store_data_align.sv
// Bench for store_data_align: directed vector table, hand-written stall /
// illegal / reset sequences, and random stores checked against a
// byte-by-byte reference model.

module tb_store_data_align;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        busy;
   logic        err_illegal;

   store_data_align #(.WIDTH(32), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .busy        (busy),
      .err_illegal (err_illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } beat_t;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      int          nb;
      beat_t       b0;
      beat_t       b1;
      int          lat;
      bit          ill;
   } vec_t;

   int    n_vec = 0;
   int    n_err = 0;

   beat_t got_b [2];
   int    got_n;
   int    got_lat;
   bit    got_ill;

   beat_t exp_b [2];
   int    exp_n;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: write each stored byte at its own byte address and group
   // the bytes by the word they land in, in address order.
   function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int          nbytes;
      logic [31:0] ba;
      logic [31:0] w;
      int          lane;
      exp_n = 0;
      exp_b[0] = '0;
      exp_b[1] = '0;
      case (f3)
         3'd0:    nbytes = 1;
         3'd1:    nbytes = 2;
         3'd2:    nbytes = 4;
         default: nbytes = 0;
      endcase
      for (int k = 0; k < nbytes; k++) begin
         ba   = a + 32'(k);
         w    = ba & 32'hFFFF_FFFC;
         lane = int'(ba & 32'd3);
         if (exp_n == 0 || exp_b[exp_n-1].addr != w) begin
            exp_b[exp_n].addr = w;
            exp_n++;
         end
         exp_b[exp_n-1].be[lane] = 1'b1;
         exp_b[exp_n-1].wdata[8*lane +: 8] = d[8*k +: 8];
      end
   endfunction

   // Issue one request from IDLE and drain it, recording each accepted beat.
   task automatic run_store(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input bit rnd);
      beat_t hold;
      bit    have_hold;
      req_valid  = 1'b1;
      req_funct3 = f3;
      req_addr   = a;
      req_data   = d;
      mem_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      req_valid  = 1'b0;
      req_data   = $urandom;
      req_addr   = $urandom;
      req_funct3 = 3'($urandom);
      got_n      = 0;
      got_b[0]   = '0;
      got_b[1]   = '0;
      got_ill    = err_illegal;
      got_lat    = 1;
      have_hold  = 1'b0;
      hold       = '0;
      while (busy && got_lat < 64) begin
         mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         chk("valid_while_busy", 64'(mem_valid), 64'd1);
         if (have_hold)
            chk("hold_stable", 64'({mem_addr, mem_wdata, mem_be}), 64'(hold));
         if (mem_valid && mem_ready) begin
            if (got_n < 2) got_b[got_n] = '{addr: mem_addr, wdata: mem_wdata, be: mem_be};
            got_n++;
            have_hold = 1'b0;
         end else if (mem_valid) begin
            hold      = '{addr: mem_addr, wdata: mem_wdata, be: mem_be};
            have_hold = 1'b1;
         end
         tick();
         got_lat++;
      end
      if (busy) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: busy still high after %0d cycles, required low", got_lat);
      end
      mem_ready = 1'b0;
      chk("valid_after_drain", 64'(mem_valid), 64'd0);
      chk("ready_after_drain", 64'(req_ready), 64'd1);
      tick();
      chk("err_pulse_width", 64'(err_illegal), 64'd0);
   endtask

   vec_t vt [8];

   initial begin
      vt[0] = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1,
                '{32'h0000_0100, 32'hDEAD_BEEF, 4'b1111}, '0, 2, 1'b0};
      vt[1] = '{3'b000, 32'h0000_0203, 32'h1234_56A5, 1,
                '{32'h0000_0200, 32'hA500_0000, 4'b1000}, '0, 2, 1'b0};
      vt[2] = '{3'b001, 32'h0000_0307, 32'h0000_BEEF, 2,
                '{32'h0000_0304, 32'hEF00_0000, 4'b1000},
                '{32'h0000_0308, 32'h0000_00BE, 4'b0001}, 3, 1'b0};
      vt[3] = '{3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 2,
                '{32'hFFFF_FFFC, 32'h3344_0000, 4'b1100},
                '{32'h0000_0000, 32'h0000_1122, 4'b0011}, 3, 1'b0};
      vt[4] = '{3'b001, 32'h0000_0102, 32'hFFFF_ABCD, 1,
                '{32'h0000_0100, 32'hABCD_0000, 4'b1100}, '0, 2, 1'b0};
      vt[5] = '{3'b000, 32'h0000_0001, 32'hFFFF_FF77, 1,
                '{32'h0000_0000, 32'h0000_7700, 4'b0010}, '0, 2, 1'b0};
      vt[6] = '{3'b011, 32'h0000_0010, 32'h5555_5555, 0, '0, '0, 1, 1'b1};
      vt[7] = '{3'b010, 32'h0000_0041, 32'hAABB_CCDD, 2,
                '{32'h0000_0040, 32'hBBCC_DD00, 4'b1110},
                '{32'h0000_0044, 32'h0000_00AA, 4'b0001}, 3, 1'b0};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_data   = '0;
      mem_ready  = 1'b1;
      tick();
      tick();
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_mem_be", 64'(mem_be), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err_illegal), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_store(vt[i].f3, vt[i].addr, vt[i].data, 1'b0);
         chk($sformatf("vec%0d_illegal", i), 64'(got_ill), 64'(vt[i].ill));
         chk($sformatf("vec%0d_nbeats", i), 64'(got_n), 64'(vt[i].nb));
         chk($sformatf("vec%0d_latency", i), 64'(got_lat), 64'(vt[i].lat));
         if (vt[i].nb > 0) begin
            chk($sformatf("vec%0d_b0_addr", i), 64'(got_b[0].addr), 64'(vt[i].b0.addr));
            chk($sformatf("vec%0d_b0_wdata", i), 64'(got_b[0].wdata), 64'(vt[i].b0.wdata));
            chk($sformatf("vec%0d_b0_be", i), 64'(got_b[0].be), 64'(vt[i].b0.be));
         end
         if (vt[i].nb > 1) begin
            chk($sformatf("vec%0d_b1_addr", i), 64'(got_b[1].addr), 64'(vt[i].b1.addr));
            chk($sformatf("vec%0d_b1_wdata", i), 64'(got_b[1].wdata), 64'(vt[i].b1.wdata));
            chk($sformatf("vec%0d_b1_be", i), 64'(got_b[1].be), 64'(vt[i].b1.be));
         end
      end

      // Memory stall for three cycles while the core changes req_data.
      mem_ready  = 1'b0;
      req_valid  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0040;
      req_data   = 32'h0102_0304;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_data = $urandom;
         if (c == 3) mem_ready = 1'b1;
         chk("stall_valid", 64'(mem_valid), 64'd1);
         chk("stall_addr", 64'(mem_addr), 64'h40);
         chk("stall_wdata", 64'(mem_wdata), 64'h0102_0304);
         chk("stall_be", 64'(mem_be), 64'hF);
         chk("stall_req_ready", 64'(req_ready), 64'd0);
         tick();
      end
      chk("stall_done_busy", 64'(busy), 64'd0);
      chk("stall_done_valid", 64'(mem_valid), 64'd0);

      // Illegal funct3 straight after: one-cycle error, no beat.
      req_valid  = 1'b1;
      req_funct3 = 3'b011;
      tick();
      req_valid = 1'b0;
      chk("ill_err_high", 64'(err_illegal), 64'd1);
      chk("ill_no_valid", 64'(mem_valid), 64'd0);
      chk("ill_busy", 64'(busy), 64'd0);
      tick();
      chk("ill_err_low", 64'(err_illegal), 64'd0);
      chk("ill_no_valid2", 64'(mem_valid), 64'd0);

      // Reset while the second beat of a split SW is pending.
      mem_ready  = 1'b1;
      req_valid  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0041;
      req_data   = 32'hCAFE_F00D;
      tick();
      req_valid = 1'b0;
      chk("split_b0_be", 64'(mem_be), 64'hE);
      tick();
      chk("split_b1_be", 64'(mem_be), 64'h1);
      chk("split_b1_addr", 64'(mem_addr), 64'h44);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      tick();
      chk("midrst_valid", 64'(mem_valid), 64'd0);
      chk("midrst_be", 64'(mem_be), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd1);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("midrst_no_beat1", 64'(mem_valid), 64'd0);
      end

      // Random stores with random memory back-pressure.
      for (int i = 0; i < 300; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         logic [31:0] d;
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
         d  = $urandom;
         model(f3, a, d);
         run_store(f3, a, d, 1'b1);
         chk("rnd_illegal", 64'(got_ill), 64'(f3 > 3'd2));
         chk("rnd_nbeats", 64'(got_n), 64'(exp_n));
         for (int b = 0; b < exp_n; b++) begin
            chk("rnd_addr", 64'(got_b[b].addr), 64'(exp_b[b].addr));
            chk("rnd_wdata", 64'(got_b[b].wdata), 64'(exp_b[b].wdata));
            chk("rnd_be", 64'(got_b[b].be), 64'(exp_b[b].be));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
